rom_loader: RTL and testbench
=============================

Name: rom_loader

Overview:
- Boot-time program loader sitting directly upstream of the ROM module.
- Receives a byte stream over a valid/ready handshake, assembles big-endian 16-bit words, and issues single-cycle writes into ROM address space.
- Holds write_protect deasserted only while a load is in progress.
- Its wr_addr/wr_data/wr_en outputs are muxed onto write_bus/data_bus/write_clk by the system glue.

Parameters:
- ADDR_BASE, 16'h8000, first ROM address; word i is written to ADDR_BASE+i.
- DEPTH, 32768, ROM capacity in words; the maximum legal load length.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a load from IDLE/DONE/ERROR, ignored while busy.
- abort  input  1  while busy, forces ERROR on the next edge.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data is valid.
- rx_ready  output  1  loader accepts a byte this cycle.
- wr_addr  output  16  ROM write address.
- wr_data  output  16  ROM write data.
- wr_en  output  1  one-cycle write strobe.
- write_protect  output  1  1 = ROM writes blocked.
- busy  output  1  load in progress.
- done  output  1  last load completed successfully; sticky until the next start.
- error  output  1  last load failed; sticky until the next start.
- word_count  output  16  words written so far in the current load.

Behaviour:
- **Reset** (reset==0 at a rising edge): state=IDLE, rx_ready=0, wr_en=0, write_protect=1, busy=0, done=0, error=0, wr_addr=ADDR_BASE, wr_data=0, word_count=0, length register=0. Reset mid-load discards the load; words already written stay in ROM.
- **Byte acceptance:** a byte is accepted on an edge where rx_valid && rx_ready. rx_ready is a registered output: 1 in LEN_HI, LEN_LO, DATA_HI, DATA_LO (and CHK_HI, CHK_LO), 0 in all other states. rx_data is ignored when rx_ready==0.
- **States:**
  - IDLE/DONE/ERROR --start--> LEN_HI. On that edge: busy=1, write_protect=0, done=0, error=0, word_count=0, wr_addr=ADDR_BASE.
  - LEN_HI: accept byte -> len[15:8] -> LEN_LO.
  - LEN_LO: accept byte -> len[7:0]. Then:
    - len==0 -> DONE (or CHK_HI with the feature).
    - len>DEPTH -> ERROR.
    - otherwise -> DATA_HI.
  - DATA_HI: accept byte -> wr_data[15:8] -> DATA_LO.
  - DATA_LO: accept byte -> wr_data[7:0] -> WRITE.
  - WRITE: exactly one cycle with wr_en=1, wr_addr=ADDR_BASE+word_count, stable wr_data. Next edge: word_count+1, wr_addr+1.
    - If the new word_count==len -> DONE (or CHK_HI).
    - Else -> DATA_HI.
  - DONE: busy=0, write_protect=1, done=1.
  - ERROR: busy=0, write_protect=1, error=1, wr_en=0.
- **Latency:** minimum 3 cycles per word (2 byte-accept cycles plus 1 WRITE cycle); back-to-back valid bytes are supported.
- **Arithmetic:**
  - wr_addr is computed mod 2^16.
  - With default parameters, len==DEPTH ends at 16'hFFFF and never wraps.
- **Abort:**
  - abort while busy, including during WRITE: that edge completes any WRITE strobe already asserted, then state=ERROR.
  - abort while not busy: no effect.
  - abort and start in the same cycle while idle: start wins.
- **Busy gating:**
  - start while busy: ignored.
  - write_protect==0 if and only if busy==1.

Optional Feature:
- Macro: ROM_LOADER_CHECKSUM_EN.
- Defined:
  - The loader keeps a 16-bit modular sum of all written data words, cleared on start.
  - After the last WRITE (or after LEN_LO when len==0), the loader goes CHK_HI -> CHK_LO, accepting a big-endian 16-bit checksum.
  - Match -> DONE. Mismatch -> ERROR; written words remain.
- Undefined: no CHK states and no sum register; DONE follows the final WRITE directly.

Test Plan:
1. Reset held low for 2 cycles, then released -> write_protect=1, wr_en=0, rx_ready=0, busy=0, wr_addr=16'h8000 at every edge.
2. start, then bytes 00 02 12 34 AB CD with rx_valid held high -> exactly two wr_en pulses: (16'h8000, 16'h1234) then (16'h8001, 16'hABCD); then done=1, write_protect=1, word_count=2.
3. start, length bytes 80 01 (32769 > DEPTH) -> error=1, no wr_en pulse, write_protect=1.
4. start, length 00 03, one data word, then abort pulse -> exactly one write at 16'h8000, then error=1, busy=0; a subsequent start clears error.
5. Load in progress, reset driven low in DATA_LO -> next edge returns all outputs to reset values; no wr_en pulse.
6. ROM_LOADER_CHECKSUM_EN defined, length 00 02, words 0001 FFFF:
   - checksum 00 00 -> done=1.
   - Repeat with checksum 00 01 -> error=1; both words still written.

Source files
------------

// File: rtl/rom_loader.sv
// Boot-time ROM loader: assembles big-endian 16-bit words from a byte stream and strobes them into ROM.
// Optional trailing checksum check is enabled by defining ROM_LOADER_CHECKSUM_EN.
module rom_loader #(
    parameter logic [15:0] ADDR_BASE = 16'h8000,
    parameter int unsigned DEPTH     = 32768
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [15:0] wr_addr,
    output logic [15:0] wr_data,
    output logic        wr_en,
    output logic        write_protect,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] word_count
);

    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_LEN_HI  = 4'd1;
    localparam logic [3:0] ST_LEN_LO  = 4'd2;
    localparam logic [3:0] ST_DATA_HI = 4'd3;
    localparam logic [3:0] ST_DATA_LO = 4'd4;
    localparam logic [3:0] ST_WRITE   = 4'd5;
    localparam logic [3:0] ST_DONE    = 4'd8;
    localparam logic [3:0] ST_ERROR   = 4'd9;
`ifdef ROM_LOADER_CHECKSUM_EN
    localparam logic [3:0] ST_CHK_HI  = 4'd6;
    localparam logic [3:0] ST_CHK_LO  = 4'd7;
    localparam logic [3:0] ST_FINAL   = ST_CHK_HI;
`else
    localparam logic [3:0] ST_FINAL   = ST_DONE;
`endif
    localparam logic [16:0] DEPTH_C   = 17'(DEPTH);

    logic [3:0]  state_r, state_nxt_s;
    logic [15:0] len_r, len_nxt_s;
    logic [15:0] addr_r, addr_nxt_s;
    logic [15:0] data_r, data_nxt_s;
    logic [15:0] count_r, count_nxt_s;
    logic        rx_ready_r, rx_ready_nxt_s;
    logic        wr_en_r, wr_en_nxt_s;
    logic        busy_r, busy_nxt_s;
    logic        wp_r;
    logic        done_r, done_nxt_s;
    logic        error_r, error_nxt_s;
    logic        accept_s;
    logic [15:0] len_lo_s;
`ifdef ROM_LOADER_CHECKSUM_EN
    logic [15:0] sum_r, sum_nxt_s;
    logic [7:0]  chk_hi_r, chk_hi_nxt_s;
`endif

    assign accept_s = rx_valid && rx_ready_r;
    assign len_lo_s = {len_r[15:8], rx_data};

    // Next-state and datapath update; busy_r gates start and abort.
    always_comb begin
        state_nxt_s = state_r;
        len_nxt_s   = len_r;
        addr_nxt_s  = addr_r;
        data_nxt_s  = data_r;
        count_nxt_s = count_r;
`ifdef ROM_LOADER_CHECKSUM_EN
        sum_nxt_s    = sum_r;
        chk_hi_nxt_s = chk_hi_r;
`endif
        if (!busy_r) begin
            if (start) begin
                state_nxt_s = ST_LEN_HI;
                count_nxt_s = 16'd0;
                addr_nxt_s  = ADDR_BASE;
`ifdef ROM_LOADER_CHECKSUM_EN
                sum_nxt_s   = 16'd0;
`endif
            end else begin
                state_nxt_s = state_r;
            end
        end else if (abort) begin
            // A strobe already on the bus is sampled at this edge, so account for it.
            if (state_r == ST_WRITE) begin
                count_nxt_s = count_r + 16'd1;
                addr_nxt_s  = addr_r + 16'd1;
`ifdef ROM_LOADER_CHECKSUM_EN
                sum_nxt_s   = sum_r + data_r;
`endif
            end else begin
                count_nxt_s = count_r;
            end
            state_nxt_s = ST_ERROR;
        end else begin
            case (state_r)
                ST_LEN_HI: begin
                    if (accept_s) begin
                        len_nxt_s   = {rx_data, len_r[7:0]};
                        state_nxt_s = ST_LEN_LO;
                    end else begin
                        state_nxt_s = ST_LEN_HI;
                    end
                end
                ST_LEN_LO: begin
                    if (accept_s) begin
                        len_nxt_s = len_lo_s;
                        if (len_lo_s == 16'd0) begin
                            state_nxt_s = ST_FINAL;
                        end else if ({1'b0, len_lo_s} > DEPTH_C) begin
                            state_nxt_s = ST_ERROR;
                        end else begin
                            state_nxt_s = ST_DATA_HI;
                        end
                    end else begin
                        state_nxt_s = ST_LEN_LO;
                    end
                end
                ST_DATA_HI: begin
                    if (accept_s) begin
                        data_nxt_s  = {rx_data, data_r[7:0]};
                        state_nxt_s = ST_DATA_LO;
                    end else begin
                        state_nxt_s = ST_DATA_HI;
                    end
                end
                ST_DATA_LO: begin
                    if (accept_s) begin
                        data_nxt_s  = {data_r[15:8], rx_data};
                        state_nxt_s = ST_WRITE;
                    end else begin
                        state_nxt_s = ST_DATA_LO;
                    end
                end
                ST_WRITE: begin
                    count_nxt_s = count_r + 16'd1;
                    addr_nxt_s  = addr_r + 16'd1;
`ifdef ROM_LOADER_CHECKSUM_EN
                    sum_nxt_s   = sum_r + data_r;
`endif
                    if (16'(count_r + 16'd1) == len_r) begin
                        state_nxt_s = ST_FINAL;
                    end else begin
                        state_nxt_s = ST_DATA_HI;
                    end
                end
`ifdef ROM_LOADER_CHECKSUM_EN
                ST_CHK_HI: begin
                    if (accept_s) begin
                        chk_hi_nxt_s = rx_data;
                        state_nxt_s  = ST_CHK_LO;
                    end else begin
                        state_nxt_s  = ST_CHK_HI;
                    end
                end
                ST_CHK_LO: begin
                    if (accept_s) begin
                        if ({chk_hi_r, rx_data} == sum_r) begin
                            state_nxt_s = ST_DONE;
                        end else begin
                            state_nxt_s = ST_ERROR;
                        end
                    end else begin
                        state_nxt_s = ST_CHK_LO;
                    end
                end
`endif
                default: state_nxt_s = ST_ERROR;
            endcase
        end
    end

    // Decode registered status outputs from the upcoming state.
    always_comb begin
        rx_ready_nxt_s = 1'b0;
        wr_en_nxt_s    = 1'b0;
        busy_nxt_s     = 1'b1;
        done_nxt_s     = 1'b0;
        error_nxt_s    = 1'b0;
        case (state_nxt_s)
            ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO: rx_ready_nxt_s = 1'b1;
`ifdef ROM_LOADER_CHECKSUM_EN
            ST_CHK_HI, ST_CHK_LO: rx_ready_nxt_s = 1'b1;
`endif
            ST_WRITE: wr_en_nxt_s = 1'b1;
            ST_DONE: begin
                busy_nxt_s = 1'b0;
                done_nxt_s = 1'b1;
            end
            ST_ERROR: begin
                busy_nxt_s  = 1'b0;
                error_nxt_s = 1'b1;
            end
            default: busy_nxt_s = 1'b0;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            len_r      <= 16'd0;
            addr_r     <= ADDR_BASE;
            data_r     <= 16'd0;
            count_r    <= 16'd0;
            rx_ready_r <= 1'b0;
            wr_en_r    <= 1'b0;
            busy_r     <= 1'b0;
            wp_r       <= 1'b1;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
            sum_r      <= 16'd0;
            chk_hi_r   <= 8'd0;
`endif
        end else begin
            state_r    <= state_nxt_s;
            len_r      <= len_nxt_s;
            addr_r     <= addr_nxt_s;
            data_r     <= data_nxt_s;
            count_r    <= count_nxt_s;
            rx_ready_r <= rx_ready_nxt_s;
            wr_en_r    <= wr_en_nxt_s;
            busy_r     <= busy_nxt_s;
            wp_r       <= !busy_nxt_s;
            done_r     <= done_nxt_s;
            error_r    <= error_nxt_s;
`ifdef ROM_LOADER_CHECKSUM_EN
            sum_r      <= sum_nxt_s;
            chk_hi_r   <= chk_hi_nxt_s;
`endif
        end
    end

    assign rx_ready      = rx_ready_r;
    assign wr_addr       = addr_r;
    assign wr_data       = data_r;
    assign wr_en         = wr_en_r;
    assign write_protect = wp_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign error         = error_r;
    assign word_count    = count_r;

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader: table-driven loads plus hand sequences, writes checked via a scoreboard queue.
module tb_rom_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_en;
    logic        write_protect;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] word_count;

    int total = 0;
    int bad = 0;
    logic [31:0] sb_q[$];

    typedef struct {
        logic [15:0] len;
        int          nwords;
        logic [15:0] w[3];
        logic        exp_done;
        logic        exp_error;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[5];

    rom_loader dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
        .write_protect(write_protect), .busy(busy), .done(done),
        .error(error), .word_count(word_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Write monitor and write_protect/busy invariant, sampled on the falling edge.
    always @(negedge clk) begin
        check("wp_vs_busy", {31'd0, write_protect}, {31'd0, !busy});
        if (wr_en === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_write", {wr_addr, wr_data}, 32'hxxxx_xxxx);
            end else begin
                check("write", {wr_addr, wr_data}, sb_q.pop_front());
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (rx_ready !== 1'b1) check("rx_ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy === 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic check_status(input string tag, input logic d, input logic e, input logic [15:0] cnt);
        check({tag, "_done"}, {31'd0, done}, {31'd0, d});
        check({tag, "_error"}, {31'd0, error}, {31'd0, e});
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_wp"}, {31'd0, write_protect}, 32'd1);
        check({tag, "_count"}, {16'd0, word_count}, {16'd0, cnt});
        check({tag, "_sb_empty"}, sb_q.size(), 32'd0);
    endtask

    initial begin
        logic [15:0] sum;

        vecs[0] = '{len: 16'd2,     nwords: 2, w: '{16'h1234, 16'hABCD, 16'h0000}, exp_done: 1'b1, exp_error: 1'b0, exp_cnt: 16'd2};
        vecs[1] = '{len: 16'h8001,  nwords: 0, w: '{16'h0000, 16'h0000, 16'h0000}, exp_done: 1'b0, exp_error: 1'b1, exp_cnt: 16'd0};
        vecs[2] = '{len: 16'd0,     nwords: 0, w: '{16'h0000, 16'h0000, 16'h0000}, exp_done: 1'b1, exp_error: 1'b0, exp_cnt: 16'd0};
        vecs[3] = '{len: 16'd3,     nwords: 3, w: '{16'h0000, 16'hFFFF, 16'h5A5A}, exp_done: 1'b1, exp_error: 1'b0, exp_cnt: 16'd3};
        vecs[4] = '{len: 16'd1,     nwords: 1, w: '{16'hBEEF, 16'h0000, 16'h0000}, exp_done: 1'b1, exp_error: 1'b0, exp_cnt: 16'd1};

        // Reset held for two edges, then released.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 1) reset = 1'b1;
            check("rst_wp", {31'd0, write_protect}, 32'd1);
            check("rst_wr_en", {31'd0, wr_en}, 32'd0);
            check("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
            check("rst_busy", {31'd0, busy}, 32'd0);
            check("rst_wr_addr", {16'd0, wr_addr}, 32'h0000_8000);
        end

        for (int v = 0; v < 5; v++) begin
            sum = 16'd0;
            pulse_start();
            check("start_busy", {31'd0, busy}, 32'd1);
            check("start_done_clr", {31'd0, done}, 32'd0);
            check("start_count", {16'd0, word_count}, 32'd0);
            send_word(vecs[v].len);
            for (int i = 0; i < vecs[v].nwords; i++) begin
                sb_q.push_back({16'h8000 + 16'(i), vecs[v].w[i]});
                sum = sum + vecs[v].w[i];
                send_word(vecs[v].w[i]);
            end
`ifdef ROM_LOADER_CHECKSUM_EN
            if (!vecs[v].exp_error) send_word(sum);
`endif
            wait_idle();
            check_status($sformatf("vec%0d", v), vecs[v].exp_done, vecs[v].exp_error, vecs[v].exp_cnt);
        end

        // Abort after one written word; a following start clears error.
        pulse_start();
        send_word(16'd3);
        sb_q.push_back({16'h8000, 16'h4321});
        send_word(16'h4321);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_status("abort", 1'b0, 1'b1, 16'd1);
        pulse_start();
        check("restart_err_clr", {31'd0, error}, 32'd0);
        check("restart_busy", {31'd0, busy}, 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_status("abort2", 1'b0, 1'b1, 16'd0);

        // Start while busy is ignored; abort while idle has no effect.
        pulse_start();
        send_word(16'd1);
        pulse_start();
        sb_q.push_back({16'h8000, 16'h7E57});
        send_word(16'h7E57);
`ifdef ROM_LOADER_CHECKSUM_EN
        send_word(16'h7E57);
`endif
        wait_idle();
        check_status("start_busy_ign", 1'b1, 1'b0, 16'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_status("abort_idle", 1'b1, 1'b0, 16'd1);

        // Start and abort together while idle: start wins.
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("start_wins_busy", {31'd0, busy}, 32'd1);
        check("start_wins_err", {31'd0, error}, 32'd0);

        // Reset while in DATA_LO discards the load.
        send_word(16'd2);
        send_byte(8'h11);
        reset    = 1'b0;
        rx_data  = 8'h22;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        check("mid_rst_rx_ready", {31'd0, rx_ready}, 32'd0);
        check("mid_rst_wr_data", {16'd0, wr_data}, 32'd0);
        check("mid_rst_wr_addr", {16'd0, wr_addr}, 32'h0000_8000);
        check("mid_rst_wr_en", {31'd0, wr_en}, 32'd0);
        check_status("mid_rst", 1'b0, 1'b0, 16'd0);
        reset = 1'b1;
        @(negedge clk);

`ifdef ROM_LOADER_CHECKSUM_EN
        // Checksum match then mismatch over words 0001 FFFF.
        for (int k = 0; k < 2; k++) begin
            pulse_start();
            send_word(16'd2);
            sb_q.push_back({16'h8000, 16'h0001});
            send_word(16'h0001);
            sb_q.push_back({16'h8001, 16'hFFFF});
            send_word(16'hFFFF);
            send_word(16'(k));
            wait_idle();
            check_status($sformatf("chk%0d", k), (k == 0), (k == 1), 16'd2);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
